// File: rtl/sll_iter_unit.sv
// sll_iter_unit: iterative shift-left-logical unit, STEP bits per cycle, valid/ready on both sides.
// Optional sticky overflow output `ovf` is built only when SLL_OVF_FLAG_EN is defined.
module sll_iter_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_low,
    output logic             one_signal
`ifdef SLL_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW   = $clog2(WIDTH);
    localparam int SW   = $clog2(STEP) + 1;
    localparam int CNTW = (CW > SW) ? CW : SW;
    localparam logic [WIDTH-1:0] W_LIM  = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  STEP_C = CNTW'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_res, w_res_next;
    logic [WIDTH-1:0] r_a_lat, w_a_lat_next;
    logic [CNTW-1:0]  r_count, w_count_next;
    logic             r_out_valid, w_out_valid_next;
    logic             r_one, w_one_next;

    logic             w_idle;
    logic             w_b_zero;
    logic             w_b_big;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_shifted;
    logic [CNTW-1:0]  w_cnt;
    logic [CNTW-1:0]  w_n;
    logic [CNTW-1:0]  w_cnt_rem;

    // One shifter serves both the accept edge and SHIFT: the first step is
    // folded into the accept so an op needs ceil(b/STEP) edges in total.
    assign w_idle    = (r_state == IDLE);
    assign w_b_zero  = (b == '0);
    assign w_b_big   = (b >= W_LIM);
    assign w_src     = w_idle ? a : r_res;
    assign w_cnt     = w_idle ? CNTW'(b[CW-1:0]) : r_count;
    assign w_n       = (w_cnt < STEP_C) ? w_cnt : STEP_C;
    assign w_cnt_rem = w_cnt - w_n;

`ifdef SLL_OVF_FLAG_EN
    logic                  r_ovf, w_ovf_next;
    logic [WIDTH+STEP-1:0] w_wide;
    logic                  w_lost;

    // The top STEP bits of the widened shift are exactly the bits pushed out.
    assign w_wide    = {{STEP{1'b0}}, w_src} << w_n;
    assign w_shifted = w_wide[WIDTH-1:0];
    assign w_lost    = (w_wide[WIDTH+STEP-1:WIDTH] != '0);
    assign ovf       = r_ovf;
`else
    assign w_shifted = w_src << w_n;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_res_next       = r_res;
        w_a_lat_next     = r_a_lat;
        w_count_next     = r_count;
        w_out_valid_next = r_out_valid;
        w_one_next       = r_one;
`ifdef SLL_OVF_FLAG_EN
        w_ovf_next       = r_ovf;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_a_lat_next = a;
                    w_one_next   = 1'b0;
`ifdef SLL_OVF_FLAG_EN
                    w_ovf_next   = 1'b0;
`endif
                    if (w_b_zero) begin
                        w_res_next       = a;
                        w_count_next     = '0;
                        w_state_next     = DONE;
                        w_out_valid_next = 1'b1;
                    end else if (w_b_big) begin
                        w_res_next       = '0;
                        w_count_next     = '0;
                        w_state_next     = DONE;
                        w_out_valid_next = 1'b1;
                        w_one_next       = (a != '0);
`ifdef SLL_OVF_FLAG_EN
                        w_ovf_next       = (a != '0);
`endif
                    end else begin
                        w_res_next   = w_shifted;
                        w_count_next = w_cnt_rem;
`ifdef SLL_OVF_FLAG_EN
                        w_ovf_next   = w_lost;
`endif
                        if (w_cnt_rem == '0) begin
                            w_state_next     = DONE;
                            w_out_valid_next = 1'b1;
                            w_one_next       = (a != '0) && (w_shifted == '0);
                        end else begin
                            w_state_next = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                w_res_next   = w_shifted;
                w_count_next = w_cnt_rem;
`ifdef SLL_OVF_FLAG_EN
                w_ovf_next   = r_ovf | w_lost;
`endif
                if (w_cnt_rem == '0) begin
                    w_state_next     = DONE;
                    w_out_valid_next = 1'b1;
                    w_one_next       = (r_a_lat != '0) && (w_shifted == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next     = IDLE;
                    w_out_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_res       <= '0;
            r_a_lat     <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_one       <= 1'b0;
`ifdef SLL_OVF_FLAG_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_res       <= w_res_next;
            r_a_lat     <= w_a_lat_next;
            r_count     <= w_count_next;
            r_out_valid <= w_out_valid_next;
            r_one       <= w_one_next;
`ifdef SLL_OVF_FLAG_EN
            r_ovf       <= w_ovf_next;
`endif
        end
    end

    assign in_ready   = w_idle;
    assign out_valid  = r_out_valid;
    assign res_low    = r_res;
    assign one_signal = r_one;

endmodule

// File: tb/tb_sll_iter_unit.sv
// Bench for sll_iter_unit: STEP=1 and STEP=4 instances share one input stream and are
// checked against a plain-arithmetic model of result, one_signal, latency (and ovf).
module tb_sll_iter_unit;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    logic        ir1, ov1, one1;
    logic [31:0] res1;
    logic        ir4, ov4, one4;
    logic [31:0] res4;
`ifdef SLL_OVF_FLAG_EN
    logic        ovf1, ovf4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    sll_iter_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
        .res_low(res1), .one_signal(one1)
`ifdef SLL_OVF_FLAG_EN
        , .ovf(ovf1)
`endif
    );

    sll_iter_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir4),
        .a(a), .b(b), .out_valid(ov4), .out_ready(out_ready),
        .res_low(res4), .one_signal(one4)
`ifdef SLL_OVF_FLAG_EN
        , .ovf(ovf4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation through both instances; hold = cycles of back-pressure in DONE,
    // poke = offer a competing operation while the result is being held.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                          input int hold, input bit poke);
        logic [31:0] er;
        logic        eo;
        logic [63:0] wide;
        logic        eovf;
        int          el1, el4, lat1, lat4, k;

        er   = (tbv >= 32) ? 32'd0 : (ta << tbv);
        eo   = (ta != 32'd0) && (er == 32'd0);
        wide = {32'd0, ta} << tbv;
        eovf = (tbv == 32'd0) ? 1'b0 : (tbv >= 32) ? (ta != 32'd0) : (wide[63:32] != 32'd0);
        el1  = (tbv == 32'd0 || tbv >= 32) ? 1 : int'(tbv);
        el4  = (tbv == 32'd0 || tbv >= 32) ? 1 : (int'(tbv) + 3) / 4;

        @(negedge clock);
        check("in_ready_idle_s1", 64'(ir1), 64'd1);
        check("in_ready_idle_s4", 64'(ir4), 64'd1);
        a = ta; b = tbv; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;

        lat1 = 0; lat4 = 0; k = 1;
        while ((lat1 == 0 || lat4 == 0) && k <= 64) begin
            if (ov1 && lat1 == 0) lat1 = k;
            if (ov4 && lat4 == 0) lat4 = k;
            if (lat1 == 0 || lat4 == 0) begin
                @(posedge clock); #1;
                k++;
            end
        end

        check("latency_s1", 64'(lat1), 64'(el1));
        check("latency_s4", 64'(lat4), 64'(el4));
        check("res_s1", 64'(res1), 64'(er));
        check("res_s4", 64'(res4), 64'(er));
        check("one_s1", 64'(one1), 64'(eo));
        check("one_s4", 64'(one4), 64'(eo));
`ifdef SLL_OVF_FLAG_EN
        check("ovf_s1", 64'(ovf1), 64'(eovf));
        check("ovf_s4", 64'(ovf4), 64'(eovf));
`endif
        $display("op a=%08h b=%08h res1=%08h res4=%08h one=%0d/%0d lat=%0d/%0d exp_res=%08h exp_lat=%0d/%0d ovf_model=%0d",
                 ta, tbv, res1, res4, one1, one4, lat1, lat4, er, el1, el4, eovf);

        if (poke) begin
            a = ~ta; b = 32'd1; in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("hold_res_s1", 64'(res1), 64'(er));
            check("hold_res_s4", 64'(res4), 64'(er));
            check("hold_valid_s1", 64'(ov1), 64'd1);
            check("hold_ready_s4", 64'(ir4), 64'd0);
        end

        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("release_valid_s1", 64'(ov1), 64'd0);
        check("release_valid_s4", 64'(ov4), 64'd0);
        check("release_ready_s1", 64'(ir1), 64'd1);
        check("release_ready_s4", 64'(ir4), 64'd1);
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;

        reset_n = 1'b0; in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'd3; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        check("reset_ready", 64'(ir1), 64'd1);
        check("reset_valid", 64'(ov1), 64'd0);
        check("reset_res", 64'(res1), 64'd0);
        check("reset_one", 64'(one4), 64'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_op(32'h0000_0001, 32'd4, 0, 1'b0);
        run_op(32'hF000_0000, 32'd4, 0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(32'h1234_5678, 32'd32, 0, 1'b0);
        run_op(32'h8000_0001, 32'd1, 0, 1'b0);
        run_op(32'h8000_0001, 32'd9, 0, 1'b0);
        run_op(32'h0000_0003, 32'd2, 5, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'h0000_0000, 32'd7, 0, 1'b0);
        run_op(32'hA5A5_A5A5, 32'd31, 1, 1'b0);

        // Reset during the second SHIFT cycle must drop everything at once.
        @(negedge clock);
        a = 32'h0000_00FF; b = 32'd20; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        check("midrst_valid_s1", 64'(ov1), 64'd0);
        check("midrst_res_s1", 64'(res1), 64'd0);
        check("midrst_ready_s1", 64'(ir1), 64'd1);
        check("midrst_ready_s4", 64'(ir4), 64'd1);
        check("midrst_res_s4", 64'(res4), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(32'h0000_0001, 32'd1, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom;
            else rb = 32'($urandom_range(0, 33));
            run_op(ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
